// File: rtl/irqc_pkg.sv
// Shared definitions for the 8-input interrupt controller: register offsets,
// request-vector type, FSM states and reset defaults.
package irqc_pkg;

    localparam int NUM_IRQ = 8;

    // Word offsets inside the controller's 4-word IO window
    localparam logic [1:0] IRQC_MASK       = 2'd0;
    localparam logic [1:0] IRQC_PENDING    = 2'd1;
    localparam logic [1:0] IRQC_IN_SERVICE = 2'd2;
    localparam logic [1:0] IRQC_EOI        = 2'd3;

    localparam logic [7:0]  IRQC_MASK_RESET = 8'hC0;
    localparam logic [15:0] IRQC_SPURIOUS   = 16'h0007;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } irqc_state_t;

    // One-hot request vector selecting line idx
    function automatic irq_vec_t irq_onehot(input logic [2:0] idx);
        irq_onehot = irq_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-facing bus of the interrupt controller: register access port plus the
// INT / INTACK / vector handshake.
interface irq_controller_if;

    logic [1:0]  reg_sel;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        int_out;
    logic        intack;
    logic [15:0] vector;

    // CPU / top-level decode side
    modport master (
        output reg_sel, reg_wr, reg_wdata, intack,
        input  reg_rdata, int_out, vector
    );

    // Interrupt controller side
    modport slave (
        input  reg_sel, reg_wr, reg_wdata, intack,
        output reg_rdata, int_out, vector
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the 8 request lines.
module irq_prio_enc
    import irqc_pkg::*;
(
    input  irq_vec_t   req,
    output logic       vld,
    output logic [2:0] idx
);

    // Scan from the top so the lowest set index is the last one assigned
    always_comb begin
        vld = 1'b0;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Programmable 8-input interrupt controller.
// Latches requests, masks them, arbitrates by fixed priority (bit 0 highest)
// against the in-service set and runs the INT / INTACK handshake with the CPU.
// Build option: define IRQ_EDGE_EN for edge-triggered sticky pending bits;
// the default build samples the request lines as levels.
module irq_controller
    import irqc_pkg::*;
#(
    parameter irq_vec_t    MASK_RESET   = IRQC_MASK_RESET,
    parameter logic [15:0] SPURIOUS_VEC = IRQC_SPURIOUS
)(
    input  logic      clk,
    input  logic      rst,
    input  irq_vec_t  irq,
    output irq_vec_t  irq_ack,
    irq_controller_if.slave bus
);

    irqc_state_t state;
    irq_vec_t    mask;
    irq_vec_t    pending;
    irq_vec_t    isr;
    irq_vec_t    eligible;
    irq_vec_t    accept_vec;
    irq_vec_t    isr_after_eoi;
    irq_vec_t    isr_next;
    logic        intack_p1;
    logic        intack_rise;
    logic        accept;
    logic        elig_vld;
    logic [2:0]  elig_idx;
    logic        isr_vld;
    logic [2:0]  isr_idx;
    logic        win_vld;
    logic        mask_wr;
    logic        eoi_wr;
    logic        int_q;
    logic [15:0] vector_q;

    wire unused_wdata_hi = ^bus.reg_wdata[15:8];

    assign eligible = pending & mask;

    irq_prio_enc u_elig_enc (
        .req (eligible),
        .vld (elig_vld),
        .idx (elig_idx)
    );

    irq_prio_enc u_isr_enc (
        .req (isr),
        .vld (isr_vld),
        .idx (isr_idx)
    );

    // A request may only preempt strictly lower-priority work in service
    assign win_vld = elig_vld && (!isr_vld || (elig_idx < isr_idx));

    assign intack_rise = bus.intack && !intack_p1;

    // Acceptance keys off the FSM state, not the vector value: IRQ7's vector
    // is numerically identical to the default spurious code.
    assign accept     = (state == REQ) && intack_rise;
    assign accept_vec = accept ? irq_onehot(vector_q[2:0]) : '0;

    assign mask_wr = bus.reg_wr && (bus.reg_sel == IRQC_MASK);
    assign eoi_wr  = bus.reg_wr && (bus.reg_sel == IRQC_EOI);

    // EOI retires the current highest-priority in-service bit before a
    // same-cycle acceptance adds the new one.
    assign isr_after_eoi = (eoi_wr && isr_vld) ? (isr & ~irq_onehot(isr_idx)) : isr;
    assign isr_next      = isr_after_eoi | accept_vec;

    assign bus.int_out = int_q;
    assign bus.vector  = vector_q;

    // ---- stage p1: request capture ----
`ifdef IRQ_EDGE_EN
    irq_vec_t irq_p1;
    irq_vec_t irq_p2;

    // Double-register the lines; a rising edge sets a sticky pending bit that
    // only acceptance clears, and a fresh edge wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_p1  <= '0;
            irq_p2  <= '0;
            pending <= '0;
        end else begin
            irq_p1  <= irq;
            irq_p2  <= irq_p1;
            pending <= (pending & ~accept_vec) | (irq_p1 & ~irq_p2);
        end
    end
`else
    // Level mode: pending simply mirrors the request lines one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= irq;
        end
    end
`endif

    // Software-visible mask / in-service state, ack pulse and intack history
    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= MASK_RESET;
            isr       <= '0;
            irq_ack   <= '0;
            intack_p1 <= 1'b0;
        end else begin
            if (mask_wr) begin
                mask <= bus.reg_wdata[7:0];
            end
            isr       <= isr_next;
            irq_ack   <= accept_vec;
            intack_p1 <= bus.intack;
        end
    end

    // ---- stage p2: CPU handshake ----
    // Handshake FSM with registered INT and vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            int_q    <= 1'b0;
            vector_q <= SPURIOUS_VEC;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        vector_q <= {13'b0, elig_idx};
                        int_q    <= 1'b1;
                        state    <= REQ;
                    end else begin
                        vector_q <= SPURIOUS_VEC;
                        int_q    <= 1'b0;
                    end
                end
                REQ: begin
                    if (intack_rise) begin
                        int_q <= 1'b0;
                        state <= ACK;
                    end else if (!win_vld) begin
                        int_q    <= 1'b0;
                        vector_q <= SPURIOUS_VEC;
                        state    <= IDLE;
                    end else begin
                        vector_q <= {13'b0, elig_idx};
                    end
                end
                ACK: begin
                    if (!bus.intack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    int_q    <= 1'b0;
                    vector_q <= SPURIOUS_VEC;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Register read mux; EOI is write-only and reads back as zero
    always_comb begin
        bus.reg_rdata = 16'h0000;
        case (bus.reg_sel)
            IRQC_MASK:       bus.reg_rdata = {8'h00, mask};
            IRQC_PENDING:    bus.reg_rdata = {8'h00, pending};
            IRQC_IN_SERVICE: bus.reg_rdata = {8'h00, isr};
            default:         bus.reg_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table, priority table and
// hand-written handshake sequences.
module tb_irq_controller;
    import irqc_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    irq_vec_t irq;
    irq_vec_t irq_ack;

    irq_controller_if bus ();

    irq_controller dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .irq_ack (irq_ack),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  sel;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;

    typedef struct {
        irq_vec_t    mask;
        irq_vec_t    req;
        logic        exp_int;
        logic [15:0] exp_vec;
    } prio_vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [15:0] data);
        bus.reg_sel   = sel;
        bus.reg_wdata = data;
        bus.reg_wr    = 1'b1;
        step(1);
        bus.reg_wr    = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] sel, input logic [15:0] exp);
        bus.reg_sel = sel;
        #1;
        check(name, bus.reg_rdata, exp);
    endtask

    // One-cycle intack pulse; the source drops its line when acknowledged
    task automatic ack_pulse(input string name, input irq_vec_t exp_ack);
        bus.intack = 1'b1;
        step(1);
        check(name, 16'(irq_ack), 16'(exp_ack));
        bus.intack = 1'b0;
        irq        = irq & ~exp_ack;
        step(1);
        check({name, "_end"}, 16'(irq_ack), 16'h0000);
    endtask

    // Bring IRQ6 into service with an empty in-service set
    task automatic setup_isr6();
        irq = 8'h40;
        step(3);
        ack_pulse("setup6_ack", 8'h40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reg_vec_t  rtab[7];
        prio_vec_t ptab[7];

        rtab[0] = '{IRQC_MASK,       1'b1, 16'hA55A, 16'h005A};
        rtab[1] = '{IRQC_PENDING,    1'b1, 16'h00FF, 16'h0000};
        rtab[2] = '{IRQC_IN_SERVICE, 1'b1, 16'h00FF, 16'h0000};
        rtab[3] = '{IRQC_EOI,        1'b1, 16'h0000, 16'h0000};
        rtab[4] = '{IRQC_IN_SERVICE, 1'b0, 16'h0000, 16'h0000};
        rtab[5] = '{IRQC_MASK,       1'b0, 16'h0000, 16'h005A};
        rtab[6] = '{IRQC_MASK,       1'b1, 16'h00C0, 16'h00C0};

        ptab[0] = '{8'hFF, 8'h81, 1'b1, 16'h0000};
        ptab[1] = '{8'hFE, 8'h81, 1'b1, 16'h0007};
        ptab[2] = '{8'h00, 8'hFF, 1'b0, 16'h0007};
        ptab[3] = '{8'hFF, 8'h0C, 1'b1, 16'h0002};
        ptab[4] = '{8'h0F, 8'hF0, 1'b0, 16'h0007};
        ptab[5] = '{8'h3C, 8'h30, 1'b1, 16'h0004};
        ptab[6] = '{8'hC0, 8'h20, 1'b0, 16'h0007};

        rst           = 1'b1;
        irq           = '0;
        bus.intack    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_sel   = IRQC_MASK;
        bus.reg_wdata = '0;
        step(3);

        check("rst_int_out", 16'(bus.int_out), 16'h0000);
        check("rst_vector", bus.vector, 16'h0007);
        check("rst_irq_ack", 16'(irq_ack), 16'h0000);
        check_reg("rst_mask", IRQC_MASK, 16'h00C0);
        check_reg("rst_pending", IRQC_PENDING, 16'h0000);
        check_reg("rst_isr", IRQC_IN_SERVICE, 16'h0000);
        rst = 1'b0;
        step(1);

        for (int i = 0; i < 7; i++) begin
            if (rtab[i].wr) reg_write(rtab[i].sel, rtab[i].wdata);
            check_reg($sformatf("reg_tab%0d", i), rtab[i].sel, rtab[i].exp);
        end
        check("reg_tab_int", 16'(bus.int_out), 16'h0000);

`ifdef IRQ_EDGE_EN
        // Edge on a masked line is latched, then delivered once unmasked
        reg_write(IRQC_MASK, 16'h0000);
        irq = 8'h40;
        step(1);
        irq = 8'h00;
        step(3);
        check_reg("edge_pending", IRQC_PENDING, 16'h0040);
        check("edge_masked_int", 16'(bus.int_out), 16'h0000);
        reg_write(IRQC_MASK, 16'h0040);
        step(2);
        check("edge_int", 16'(bus.int_out), 16'h0001);
        check("edge_vec", bus.vector, 16'h0006);
        ack_pulse("edge_ack", 8'h40);
        check_reg("edge_pending_clr", IRQC_PENDING, 16'h0000);
        check_reg("edge_isr", IRQC_IN_SERVICE, 16'h0040);
`else
        // Priority table with empty in-service set
        for (int i = 0; i < 7; i++) begin
            reg_write(IRQC_MASK, 16'(ptab[i].mask));
            irq = ptab[i].req;
            step(3);
            check($sformatf("prio%0d_int", i), 16'(bus.int_out), 16'(ptab[i].exp_int));
            check($sformatf("prio%0d_vec", i), bus.vector, ptab[i].exp_vec);
            irq = '0;
            step(4);
        end
        check("prio_idle_int", 16'(bus.int_out), 16'h0000);

        // Basic delivery of IRQ6
        irq = 8'h40;
        step(2);
        check("t1_int", 16'(bus.int_out), 16'h0001);
        check("t1_vec", bus.vector, 16'h0006);
        bus.intack = 1'b1;
        step(1);
        check("t1_ack", 16'(irq_ack), 16'h0040);
        check("t1_vec_ack", bus.vector, 16'h0006);
        check("t1_int_clr", 16'(bus.int_out), 16'h0000);
        bus.intack = 1'b0;
        irq = 8'h00;
        step(1);
        check("t1_ack_end", 16'(irq_ack), 16'h0000);
        check_reg("t1_isr", IRQC_IN_SERVICE, 16'h0040);

        // Lower priority blocked by in-service IRQ6 until EOI
        irq = 8'h80;
        step(4);
        check("t2_blocked", 16'(bus.int_out), 16'h0000);
        reg_write(IRQC_EOI, 16'h1234);
        check_reg("t2_isr_eoi", IRQC_IN_SERVICE, 16'h0000);
        step(1);
        check("t2_int", 16'(bus.int_out), 16'h0001);
        check("t2_vec", bus.vector, 16'h0007);
        ack_pulse("t2_ack", 8'h80);
        check_reg("t2_isr", IRQC_IN_SERVICE, 16'h0080);
        reg_write(IRQC_EOI, 16'h0000);
        check_reg("t2_isr_clr", IRQC_IN_SERVICE, 16'h0000);

        // Nesting: IRQ0 preempts in-service IRQ6, EOIs unwind in priority order
        setup_isr6();
        reg_write(IRQC_MASK, 16'h00C1);
        irq = 8'h01;
        step(3);
        check("t3_int", 16'(bus.int_out), 16'h0001);
        check("t3_vec", bus.vector, 16'h0000);
        ack_pulse("t3_ack", 8'h01);
        check_reg("t3_isr", IRQC_IN_SERVICE, 16'h0041);
        reg_write(IRQC_EOI, 16'h0000);
        check_reg("t3_eoi1", IRQC_IN_SERVICE, 16'h0040);
        reg_write(IRQC_EOI, 16'h0000);
        check_reg("t3_eoi2", IRQC_IN_SERVICE, 16'h0000);

        // EOI and acceptance in the same cycle
        setup_isr6();
        irq = 8'h01;
        step(3);
        check("sim_vec", bus.vector, 16'h0000);
        bus.intack    = 1'b1;
        bus.reg_sel   = IRQC_EOI;
        bus.reg_wdata = 16'h0000;
        bus.reg_wr    = 1'b1;
        step(1);
        bus.reg_wr = 1'b0;
        bus.intack = 1'b0;
        irq        = 8'h00;
        check("sim_ack", 16'(irq_ack), 16'h0001);
        check_reg("sim_isr", IRQC_IN_SERVICE, 16'h0001);
        reg_write(IRQC_EOI, 16'h0000);
        check_reg("sim_isr_clr", IRQC_IN_SERVICE, 16'h0000);
        step(1);

        // Winner withdrawn by a mask write; later intack is spurious
        reg_write(IRQC_MASK, 16'h00C0);
        irq = 8'h80;
        step(3);
        check("t4_int", 16'(bus.int_out), 16'h0001);
        reg_write(IRQC_MASK, 16'h0040);
        step(1);
        check("t4_drop", 16'(bus.int_out), 16'h0000);
        bus.intack = 1'b1;
        step(1);
        check("t4_spur_vec", bus.vector, 16'h0007);
        check("t4_spur_ack", 16'(irq_ack), 16'h0000);
        bus.intack = 1'b0;
        irq = 8'h00;
        step(1);
        check("t4_spur_ack2", 16'(irq_ack), 16'h0000);
        check_reg("t4_isr", IRQC_IN_SERVICE, 16'h0000);

        // Reset while in ACK with two bits in service
        reg_write(IRQC_MASK, 16'h00FF);
        irq = 8'h80;
        step(3);
        ack_pulse("t5_ack7", 8'h80);
        irq = 8'h40;
        step(2);
        check("t5_int6", 16'(bus.int_out), 16'h0001);
        check("t5_vec6", bus.vector, 16'h0006);
        bus.intack = 1'b1;
        step(1);
        check("t5_ack6", 16'(irq_ack), 16'h0040);
        check_reg("t5_isr", IRQC_IN_SERVICE, 16'h00C0);
        step(1);
        rst = 1'b1;
        step(1);
        rst        = 1'b0;
        bus.intack = 1'b0;
        irq        = 8'h00;
        check("t5_rst_int", 16'(bus.int_out), 16'h0000);
        check("t5_rst_vec", bus.vector, 16'h0007);
        check_reg("t5_rst_isr", IRQC_IN_SERVICE, 16'h0000);
        check_reg("t5_rst_mask", IRQC_MASK, 16'h00C0);
`endif

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
